// File: rtl/match_pkg.sv
// match_pkg: phase/result encodings shared by the round controller and the health block.
package match_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, INTRO = 3'd1, FIGHT = 3'd2, KO = 3'd3, MATCH_OVER = 3'd4} phase_e;
  typedef enum logic [1:0] {NONE = 2'b00, P1 = 2'b01, P2 = 2'b10, DRAW = 2'b11} result_e;
  localparam int HEALTH_MAX = 400;
endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler: one-cycle sec_tick every TICKS_PER_SEC clocks, restartable via clear.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic sec_tick
);
  localparam int W = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  logic [W-1:0] cnt_q;
  assign sec_tick = cnt_q == W'(TICKS_PER_SEC - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= (clear || sec_tick) ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/match_round_controller.sv
// match_round_controller: best-of-N round sequencer (intro, fight timer, KO hold, match over)
// driving the health block reset and gating player input.
module match_round_controller
  import match_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int INTRO_SEC     = 3,
  parameter int ROUND_SEC     = 99,
  parameter int KO_SEC        = 2,
  parameter int WINS_TO_MATCH = 2,
  parameter int MAX_ROUNDS    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] health_state,
  input  logic [8:0] health_1,
  input  logic [8:0] health_2,
  output logic       health_reset,
  output logic       fight_enable,
  output logic [2:0] phase,
  output logic [2:0] round_num,
  output logic [1:0] wins_1,
  output logic [1:0] wins_2,
  output logic [6:0] timer_sec,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner
);
  phase_e     phase_q, phase_d;
  logic       start_q, sec_tick, start_edge, last_sec, dec, match_done;
  logic       health_reset_q, fight_enable_q;
  logic [2:0] round_q;
  logic [1:0] wins_1_q, wins_2_q, round_winner_q, match_winner_q, res_d;
  logic [6:0] timer_q;

  assign start_edge = start & ~start_q;
  assign dec        = sec_tick && timer_q != 7'd0;
  assign last_sec   = sec_tick && timer_q == 7'd1;
  assign match_done = wins_1_q == 2'(WINS_TO_MATCH) || wins_2_q == 2'(WINS_TO_MATCH) || round_q == 3'(MAX_ROUNDS);
  // A KO reported by the health block outranks a simultaneous time-out.
  assign res_d = health_state != NONE ? health_state :
                 !last_sec ? NONE :
                 health_1 > health_2 ? P1 :
                 health_2 > health_1 ? P2 : DRAW;

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      IDLE, MATCH_OVER: phase_d = start_edge ? INTRO : phase_q;
      INTRO:            phase_d = last_sec ? FIGHT : INTRO;
      FIGHT:            phase_d = res_d != NONE ? KO : FIGHT;
      KO:               phase_d = !last_sec ? KO : match_done ? MATCH_OVER : INTRO;
      default:          phase_d = IDLE;
    endcase
  end

  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (phase_d != phase_q),
    .sec_tick (sec_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q        <= IDLE;
      start_q        <= 1'b0;
      health_reset_q <= 1'b0;
      fight_enable_q <= 1'b0;
      round_q        <= '0;
      wins_1_q       <= '0;
      wins_2_q       <= '0;
      timer_q        <= '0;
      round_winner_q <= NONE;
      match_winner_q <= NONE;
    end else begin
      start_q        <= start;
      phase_q        <= phase_d;
      health_reset_q <= phase_d == INTRO && phase_q != INTRO;
      fight_enable_q <= phase_d == FIGHT;
      case (phase_q)
        IDLE, MATCH_OVER: if (start_edge) begin
          wins_1_q       <= '0;
          wins_2_q       <= '0;
          round_q        <= 3'd1;
          round_winner_q <= NONE;
          match_winner_q <= NONE;
          timer_q        <= 7'(INTRO_SEC);
        end
        INTRO: timer_q <= last_sec ? 7'(ROUND_SEC) : timer_q - 7'(dec);
        FIGHT: if (res_d != NONE) begin
          round_winner_q <= res_d;
          wins_1_q       <= wins_1_q + 2'(res_d == P1 && wins_1_q != 2'd3);
          wins_2_q       <= wins_2_q + 2'(res_d == P2 && wins_2_q != 2'd3);
          timer_q        <= 7'(KO_SEC);
        end else timer_q <= timer_q - 7'(dec);
        KO: if (last_sec && match_done) begin
          match_winner_q <= wins_1_q > wins_2_q ? P1 : wins_2_q > wins_1_q ? P2 : DRAW;
          timer_q        <= '0;
        end else if (last_sec) begin
          round_q <= round_q + 3'd1;
          timer_q <= 7'(INTRO_SEC);
        end else timer_q <= timer_q - 7'(dec);
        default: timer_q <= '0;
      endcase
    end
  end

  assign health_reset = health_reset_q;
  assign fight_enable = fight_enable_q;
  assign phase        = phase_q;
  assign round_num    = round_q;
  assign wins_1       = wins_1_q;
  assign wins_2       = wins_2_q;
  assign timer_sec    = timer_q;
  assign round_winner = round_winner_q;
  assign match_winner = match_winner_q;
endmodule

// File: tb/tb_match_round_controller.sv
// tb_match_round_controller: directed bench with hand-computed expectations (4 clocks per game second).
module tb_match_round_controller;
  logic       clk = 1'b0, reset, start;
  logic [1:0] health_state;
  logic [8:0] health_1, health_2;
  logic       health_reset, fight_enable;
  logic [2:0] phase, round_num;
  logic [1:0] wins_1, wins_2, round_winner, match_winner;
  logic [6:0] timer_sec;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  match_round_controller #(
    .TICKS_PER_SEC(4), .INTRO_SEC(3), .ROUND_SEC(5), .KO_SEC(2), .WINS_TO_MATCH(2), .MAX_ROUNDS(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .health_state(health_state),
    .health_1(health_1), .health_2(health_2), .health_reset(health_reset),
    .fight_enable(fight_enable), .phase(phase), .round_num(round_num),
    .wins_1(wins_1), .wins_2(wins_2), .timer_sec(timer_sec),
    .round_winner(round_winner), .match_winner(match_winner)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else passed++;
  endtask

  task automatic restart();
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; health_state = 2'b00; health_1 = 9'd0; health_2 = 9'd0;
    step(2);
    chk("reset_outputs", {health_reset, fight_enable, phase, round_num, wins_1, wins_2, timer_sec, round_winner, match_winner}, 0);
    reset = 1'b0;
    step(3);
    chk("idle_phase", phase, 0);
    start = 1'b1;
    step(1);
    chk("intro_phase", phase, 1);
    chk("intro_round", round_num, 1);
    chk("intro_hreset_on", health_reset, 1);
    chk("intro_timer", timer_sec, 3);
    step(1);
    chk("intro_hreset_off", health_reset, 0);
    step(10);
    chk("intro_last_sec", {phase, timer_sec}, {3'd1, 7'd1});
    step(1);
    chk("fight_entry", {phase, timer_sec, fight_enable}, {3'd2, 7'd5, 1'b1});
    health_state = 2'b01;
    step(1);
    chk("p1_ko_phase", {phase, fight_enable}, {3'd3, 1'b0});
    chk("p1_ko_score", {wins_1, wins_2, round_winner}, {2'd1, 2'd0, 2'b01});
    chk("ko_timer", timer_sec, 2);
    health_state = 2'b00;
    step(7);
    chk("ko_hold", {phase, timer_sec}, {3'd3, 7'd1});
    step(1);
    chk("round2_intro", {phase, round_num, health_reset}, {3'd1, 3'd2, 1'b1});
    health_1 = 9'd100; health_2 = 9'd100;
    step(12);
    chk("r2_fight", {phase, timer_sec}, {3'd2, 7'd5});
    step(16);
    chk("r2_timer_last", {phase, timer_sec}, {3'd2, 7'd1});
    step(4);
    chk("draw_timeout", {phase, round_winner, wins_1, wins_2}, {3'd3, 2'b11, 2'd1, 2'd0});
    step(8);
    chk("round3_intro", {phase, round_num}, {3'd1, 3'd3});
    health_1 = 9'd200; health_2 = 9'd150;
    step(12);
    chk("r3_fight", phase, 2);
    step(8);
    chk("r3_timer_mid", timer_sec, 3);
    step(12);
    chk("p1_timeout", {phase, round_winner, wins_1}, {3'd3, 2'b01, 2'd2});
    step(8);
    chk("matchA_over", {phase, match_winner, round_num, timer_sec}, {3'd4, 2'b01, 3'd3, 7'd0});
    step(5);
    chk("matchA_held", {phase, match_winner, wins_1}, {3'd4, 2'b01, 2'd2});

    restart();
    chk("matchB_start", {phase, round_num, wins_1, wins_2, round_winner, match_winner, health_reset}, {3'd1, 3'd1, 2'd0, 2'd0, 2'b00, 2'b00, 1'b1});
    step(12);
    health_state = 2'b10;
    step(1);
    chk("p2_ko1", {phase, wins_2, round_winner}, {3'd3, 2'd1, 2'b10});
    restart();
    chk("start_in_ko_ignored", {phase, round_num, wins_2}, {3'd3, 3'd1, 2'd1});
    step(6);
    chk("hs_in_ko_ignored", {phase, round_num, wins_2}, {3'd1, 3'd2, 2'd1});
    step(6);
    chk("hs_in_intro_ignored", {phase, wins_2}, {3'd1, 2'd1});
    step(6);
    chk("r2_fight_entry", {phase, wins_2}, {3'd2, 2'd1});
    step(1);
    chk("p2_ko2", {phase, wins_2}, {3'd3, 2'd2});
    health_state = 2'b00;
    step(8);
    chk("matchB_over", {phase, match_winner, wins_2, round_num}, {3'd4, 2'b10, 2'd2, 3'd2});

    restart();
    chk("matchC_clear", {phase, wins_1, wins_2, round_num}, {3'd1, 2'd0, 2'd0, 3'd1});
    health_1 = 9'd50; health_2 = 9'd50;
    for (int r = 1; r <= 3; r++) begin
      step(12);
      chk("c_fight_round", {phase, round_num}, {3'd2, 3'(r)});
      step(20);
      chk("c_draw", {phase, round_winner, wins_1, wins_2}, {3'd3, 2'b11, 2'd0, 2'd0});
      step(8);
      if (r < 3) chk("c_next_intro", phase, 1);
    end
    chk("matchC_over", {phase, match_winner, round_num}, {3'd4, 2'b11, 3'd3});

    restart();
    health_1 = 9'd100; health_2 = 9'd100;
    step(12);
    step(19);
    chk("d_last_sec", {phase, timer_sec}, {3'd2, 7'd1});
    health_state = 2'b01;
    step(1);
    chk("ko_beats_timeout", {phase, round_winner, wins_1, wins_2}, {3'd3, 2'b01, 2'd1, 2'd0});
    health_state = 2'b00;
    step(8);
    step(12);
    chk("d_r2_fight", {phase, fight_enable}, {3'd2, 1'b1});
    #3 reset = 1'b1;
    #1;
    chk("async_reset", {health_reset, fight_enable, phase, round_num, wins_1, wins_2, timer_sec, round_winner, match_winner}, 0);
    start = 1'b0;
    step(1);
    reset = 1'b0;
    step(2);
    chk("idle_after_reset", {phase, round_num}, {3'd0, 3'd0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
